// File: rtl/div_unit_pkg.sv
// Shared CPU definitions used by the divider: op and state encodings, iteration
// sizing, and the hazard-unit constants that the stall request feeds.
package div_unit_pkg;

  typedef enum logic [1:0] {
    OpDiv  = 2'b00,
    OpDivu = 2'b01,
    OpRem  = 2'b10,
    OpRemu = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StDone = 2'b10
  } div_state_e;

  localparam int unsigned DivIters = 32;
  localparam int unsigned CntW     = 5;
  localparam logic [CntW-1:0] LastCnt = CntW'(DivIters - 1);

  // Hazard unit: stall_req holds PC, IF_ID and ID_EX together.
  localparam int unsigned HzHoldStages = 3;
  localparam logic [HzHoldStages-1:0] HzHoldMask = '1;

endpackage

// File: rtl/div_step.sv
// One restoring shift/compare/subtract iteration on the {remainder, quotient} register.
module div_step (
  input  logic [63:0] acc,
  input  logic [31:0] divisor,
  output logic [63:0] acc_next
);

  logic [32:0] rem_sh;
  logic [32:0] diff;

  always_comb begin
    rem_sh = acc[63:31];
    diff   = rem_sh - {1'b0, divisor};
    // Remainder stays below the divisor, so bit 32 of diff is exactly the borrow.
    if (!diff[32]) begin
      acc_next = {diff[31:0], acc[30:0], 1'b1};
    end else begin
      acc_next = {acc[62:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle RV32M divider: 32-iteration restoring core with single-cycle handling
// of divide-by-zero and signed overflow, and a stall request for the hazard unit.
module div_unit
  import div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        flush,
  output logic        stall_req,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  div_state_e state_q, state_d;
  div_op_e    op_in, op_q;

  logic [CntW-1:0] cnt_q;
  logic [63:0]     acc_q, step_acc;
  logic [31:0]     dvsr_q, result_q;
  logic            q_neg_q, r_neg_q;

  logic        accept, in_signed, in_rem, dvd_neg, dvs_neg, div_zero, overflow, special;
  logic        is_rem_q, last;
  logic [31:0] dvd_mag, dvs_mag, special_res, quo, rem, final_res;

  always_comb begin
    op_in     = div_op_e'(op);
    in_signed = (op_in == OpDiv) || (op_in == OpRem);
    in_rem    = (op_in == OpRem) || (op_in == OpRemu);
    dvd_neg   = in_signed & dividend[31];
    dvs_neg   = in_signed & divisor[31];
    dvd_mag   = dvd_neg ? (~dividend + 32'd1) : dividend;
    dvs_mag   = dvs_neg ? (~divisor + 32'd1) : divisor;
    div_zero  = (divisor == 32'd0);
    overflow  = in_signed && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);
    special   = div_zero | overflow;
    if (div_zero) begin
      special_res = in_rem ? dividend : 32'hFFFF_FFFF;
    end else begin
      special_res = in_rem ? 32'd0 : 32'h8000_0000;
    end
    accept = (state_q == StIdle) & start & ~flush;
  end

  div_step u_div_step (
    .acc      (acc_q),
    .divisor  (dvsr_q),
    .acc_next (step_acc)
  );

  always_comb begin
    last      = (cnt_q == LastCnt);
    is_rem_q  = (op_q == OpRem) || (op_q == OpRemu);
    quo       = step_acc[31:0];
    rem       = step_acc[63:32];
    if (is_rem_q) begin
      final_res = r_neg_q ? (~rem + 32'd1) : rem;
    end else begin
      final_res = q_neg_q ? (~quo + 32'd1) : quo;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = special ? StDone : StCalc;
      StCalc: begin
        if (flush) begin
          state_d = StIdle;
        end else if (last) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy      = (state_q != StIdle);
    done      = (state_q == StDone) & ~flush;
    stall_req = accept | (state_q == StCalc);
    result    = result_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OpDiv;
      cnt_q    <= '0;
      acc_q    <= '0;
      dvsr_q   <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= '0;
    end else if (accept) begin
      op_q    <= op_in;
      cnt_q   <= '0;
      acc_q   <= {32'd0, dvd_mag};
      dvsr_q  <= dvs_mag;
      q_neg_q <= dvd_neg ^ dvs_neg;
      r_neg_q <= dvd_neg;
      if (special) begin
        result_q <= special_res;
      end
    end else if ((state_q == StCalc) && !flush) begin
      acc_q <= step_acc;
      cnt_q <= cnt_q + 1'b1;
      if (last) begin
        result_q <= final_res;
      end
    end
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have port: clk  input  1  single clock, rising-edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port: start  input  1  EX-stage divide request, sampled only in IDLE.
REQ-004 SHALL have port: op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-005 SHALL have port: dividend  input  32  rs1 value, forwarded.
REQ-006 SHALL have port: divisor  input  32  rs2 value, forwarded.
REQ-007 SHALL have port: flush  input  1  kill the in-flight operation (control hazard / ID_EX flush).
REQ-008 SHALL have port: stall_req  output  1  combinational request to the hazard unit to hold PC, IF_ID and ID_EX.
REQ-009 SHALL have port: busy  output  1  state is not IDLE.
REQ-010 SHALL have port: done  output  1  one-cycle pulse, result valid.
REQ-011 SHALL have port: result  output  32  quotient or remainder, registered.

Function
REQ-012 SHALL implement states IDLE, CALC and DONE.
REQ-013 SHALL, in IDLE with start=1 and flush=0, latch op, operand magnitudes, the quotient sign (sign XOR, signed ops) and the remainder sign (dividend sign, signed ops).
REQ-014 SHALL, on that same edge, go to DONE for special cases and to CALC with the iteration counter set to 0 otherwise.
REQ-015 SHALL treat divisor==0 as special: quotient 0xFFFFFFFF, remainder = dividend (raw), for both signed and unsigned ops.
REQ-016 SHALL treat signed overflow (dividend 0x80000000, divisor 0xFFFFFFFF, DIV/REM) as special: quotient 0x80000000, remainder 0.
REQ-017 SHALL, in CALC, perform one restoring shift-subtract step per cycle on a 64-bit {remainder, quotient} register, for exactly 32 cycles, with a counter of 0..31.
REQ-018 SHALL, after the 32nd CALC cycle, apply sign correction (two's complement negate when the latched sign is set), load result, and go to DONE.
REQ-019 SHALL assert done=1 for exactly the single DONE cycle and then return to IDLE.
REQ-020 SHALL hold result from DONE until the next accepted start.
REQ-021 SHALL drive stall_req = (IDLE & start & ~flush) | CALC, and keep it deasserted in DONE so the pipeline advances with the result.
REQ-022 SHALL meet this latency, with start accepted in cycle T: normal op done in T+33 (stall_req high T..T+32); special case done in T+1 (stall_req high in T only).
REQ-023 SHALL ignore start while busy=1.
REQ-024 SHALL, on flush=1 in any state, go to IDLE on the next edge, with no done pulse and result unchanged.
REQ-025 SHALL give flush priority over start in the same cycle: the operation is not accepted.
REQ-026 SHALL keep operand registers unaffected by changes to dividend/divisor after acceptance.

Reset
REQ-027 SHALL, on rst_n=0 asynchronously, set state=IDLE, counter=0, result=0, done=0, busy=0 and the internal registers to 0.
REQ-028 SHALL, on reset mid-operation, abandon the operation, with no done pulse after release.
REQ-029 SHALL drive stall_req=0 while in reset unless start is high (combinational in IDLE).

Structure
REQ-030 SHALL take the op encodings (DIV/DIVU/REM/REMU) and the state encodings from the shared CPU package, together with the hazard unit's constants.
REQ-031 SHALL contain one natural sub-module, div_step: a combinational single-iteration shift/compare/subtract on the 64-bit register.
REQ-032 SHALL contain no other sub-modules.

Verification
REQ-033 SHALL cover: DIVU 100/7 at T -> done at T+33, result 14; REMU same -> 2; stall_req high T..T+32.
REQ-034 SHALL cover: DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF.
REQ-035 SHALL cover: DIVU 5/0 -> 0xFFFFFFFF at T+1; REM 5/0 -> 5; stall_req high only in T.
REQ-036 SHALL cover: DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at T+1; REM same -> 0.
REQ-037 SHALL cover: flush at T+10 of DIVU 100/7 -> busy=0 and stall_req=0 at T+11, no done; a new start at T+11 completes normally at T+44.
REQ-038 SHALL cover: rst_n low at T+5 -> outputs zero immediately, no done after release; start held during busy -> ignored, single done.
